// File: rtl/dmem_mmio_responder.sv
// Data-port responder for the single-cycle core.
// Contents: word-addressed data RAM, plus one MMIO page holding a GPIO register,
// a free-running cycle counter and a byte-wide TX FIFO.
// Loads are combinational so that the core can finish a load in one cycle.
// Every state update happens on the rising clock edge.
//
// TX handshake: a byte transfers on a rising edge where tx_valid and tx_ready
// are both high. tx_valid depends only on FIFO state, never on tx_ready.
// While tx_valid is high and tx_ready is low, tx_data holds its value.
module dmem_mmio_responder #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [23:0] MMIO_PAGE  = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] gpio_out
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;

  localparam logic [7:0] OFF_GPIO   = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CYCLES = 8'h0C;

  // Address decode
  logic              is_mmio;
  logic [7:0]        offset;
  logic [RAM_AW-1:0] ram_idx;

  assign is_mmio = (aluout[31:8] == MMIO_PAGE);
  assign offset  = aluout[7:0];
  // Upper address bits are dropped on purpose, so the RAM aliases through the non-MMIO space.
  assign ram_idx = aluout[RAM_AW+1:2];

  logic ram_we, gpio_we, tx_wr, status_wr;

  assign ram_we    = memwrite && !is_mmio;
  assign gpio_we   = memwrite && is_mmio && (offset == OFF_GPIO);
  assign tx_wr     = memwrite && is_mmio && (offset == OFF_TXDATA);
  assign status_wr = memwrite && is_mmio && (offset == OFF_STATUS);

  // Data RAM storage has no reset.
  logic [31:0] ram [RAM_WORDS];

  // RAM write port. A stored word becomes readable in the cycle after the edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= writedata;
    end
  end

  // GPIO register
  logic [31:0] gpio_q;

  // GPIO loads on a store to offset 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q <= '0;
    end else if (gpio_we) begin
      gpio_q <= writedata;
    end
  end

  assign gpio_out = gpio_q;

  // Cycle counter
  logic [31:0] cycles;

  // Free-running counter. It wraps naturally, and stores to it are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // TX FIFO
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty, push, pop, ovf;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Fullness is judged before the edge, so a pop in the same cycle does not make room.
  assign push  = tx_wr && !full;
  assign pop   = tx_valid && tx_ready;

  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // FIFO byte storage. Contents are don't-care whenever count says a slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= writedata[7:0];
    end
  end

  // Pointers and count. Depth is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag. It is set by a push that gets dropped.
  // It is cleared by writing bit 2 of STATUS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (tx_wr && full) begin
      ovf <= 1'b1;
    end else if (status_wr && writedata[2]) begin
      ovf <= 1'b0;
    end
  end

  // Read mux
  logic [3:0]  count_ext;
  logic [31:0] status_word;

  assign count_ext   = 4'(count);
  assign status_word = {20'b0, count_ext, 5'b0, ovf, full, empty};

  // Combinational load data, selected by the decoded address.
  always_comb begin
    readdata = '0;
    if (is_mmio) begin
      case (offset)
        OFF_GPIO:   readdata = gpio_q;
        OFF_STATUS: readdata = status_word;
        OFF_CYCLES: readdata = cycles;
        default:    readdata = '0;
      endcase
    end else begin
      readdata = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: a vector table, hand sequences for FIFO and
// reset corners, and a randomized phase checked against a queue-based model.
module tb_dmem_mmio_responder;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_GPIO   = 32'hFFFFFF00;
  localparam logic [31:0] A_TX     = 32'hFFFFFF04;
  localparam logic [31:0] A_STATUS = 32'hFFFFFF08;
  localparam logic [31:0] A_CYCLES = 32'hFFFFFF0C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] gpio_out;

  int tests = 0;
  int fails = 0;

  dmem_mmio_responder #(
    .RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .MMIO_PAGE(24'hFFFFFF)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .gpio_out(gpio_out)
  );

  // Clock generation
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memwrite = 1'b1; aluout = addr; writedata = data;
    step();
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    aluout = addr;
    #1;
    data = readdata;
  endtask

  // Directed vector table
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp_rd;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [31:0] m_gpio;
  logic [31:0] m_cycles;
  bit          m_ovf;
  logic [7:0]  m_q[$];

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int n;
    n = m_q.size();
    if (addr[31:8] == 24'hFFFFFF) begin
      case (addr[7:0])
        8'h00: return m_gpio;
        8'h08: return {20'b0, 4'(n), 5'b0, m_ovf, (n == FIFO_DEPTH), (n == 0)};
        8'h0C: return m_cycles;
        default: return 32'h0;
      endcase
    end
    return m_ram[(addr / 4) % RAM_WORDS];
  endfunction

  // Apply one clock edge to the model, given the inputs present before the edge.
  task automatic model_edge(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic rdy);
    bit was_full;
    was_full = (m_q.size() == FIFO_DEPTH);
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (we) begin
      if (addr[31:8] == 24'hFFFFFF) begin
        case (addr[7:0])
          8'h00: m_gpio = wd;
          8'h04: if (was_full) m_ovf = 1'b1; else m_q.push_back(wd[7:0]);
          8'h08: if (wd[2]) m_ovf = 1'b0;
          default: ;
        endcase
      end else begin
        m_ram[(addr / 4) % RAM_WORDS] = wd;
        m_known[(addr / 4) % RAM_WORDS] = 1'b1;
      end
    end
    m_cycles = m_cycles + 32'd1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_gpio = '0; m_cycles = '0; m_ovf = 1'b0; m_q.delete();
  endtask

  logic [31:0] r, a, b, addr, wd;
  logic        we, rdy;

  initial begin
    // 1. Reset values
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    rd(A_STATUS, r); check("rst_status", r, 32'h1);
    rd(A_CYCLES, r); check("rst_cycles", r, 32'h0);
    step();
    rd(A_CYCLES, r); check("rst_cycles_held", r, 32'h0);
    reset = 1'b1;
    tx_ready = 1'b0;

    // 2-4. Table of register and RAM operations (tx_ready low throughout)
    vecs.push_back('{1, 32'h10,     32'hDEADBEEF, 0, 0, 0});
    vecs.push_back('{0, 32'h10,     0, 1, 32'hDEADBEEF, 0});
    vecs.push_back('{0, 32'h110,    0, 1, 32'hDEADBEEF, 0});
    vecs.push_back('{0, 32'h13,     0, 1, 32'hDEADBEEF, 0});
    vecs.push_back('{1, 32'h8000_0014, 32'h12345678, 0, 0, 0});
    vecs.push_back('{0, 32'h14,     0, 1, 32'h12345678, 0});
    vecs.push_back('{0, 32'h10,     0, 1, 32'hDEADBEEF, 0});
    vecs.push_back('{1, A_GPIO,     32'h0000A5A5, 0, 0, 0});
    vecs.push_back('{0, A_GPIO,     0, 1, 32'h0000A5A5, 32'hA5A5});
    vecs.push_back('{1, 32'hFFFFFF40, 32'hFFFF, 0, 0, 32'hA5A5});
    vecs.push_back('{0, 32'hFFFFFF40, 0, 1, 32'h0, 32'hA5A5});
    vecs.push_back('{1, A_CYCLES,   32'h0, 0, 0, 32'hA5A5});
    vecs.push_back('{0, A_TX,       0, 1, 32'h0, 32'hA5A5});
    vecs.push_back('{1, A_TX,       32'h11, 0, 0, 32'hA5A5});
    vecs.push_back('{1, A_TX,       32'h22, 0, 0, 32'hA5A5});
    vecs.push_back('{1, A_TX,       32'h33, 0, 0, 32'hA5A5});
    vecs.push_back('{1, A_TX,       32'h44, 0, 0, 32'hA5A5});
    vecs.push_back('{0, A_STATUS,   0, 1, 32'h402, 32'hA5A5});
    vecs.push_back('{1, A_TX,       32'h55, 0, 0, 32'hA5A5});
    vecs.push_back('{0, A_STATUS,   0, 1, 32'h406, 32'hA5A5});
    vecs.push_back('{1, A_STATUS,   32'hFFFFFFFB, 0, 0, 32'hA5A5});
    vecs.push_back('{0, A_STATUS,   0, 1, 32'h406, 32'hA5A5});

    foreach (vecs[i]) begin
      memwrite = vecs[i].we; aluout = vecs[i].addr; writedata = vecs[i].data;
      #1;
      check($sformatf("vec%0d_gpio", i), gpio_out, vecs[i].exp_gpio);
      if (vecs[i].chk) check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      step();
      memwrite = 1'b0;
    end

    // Drain: bytes appear in order, one per cycle, and the overflowed byte is absent.
    aluout = A_STATUS;
    check("drain_stable", 32'(tx_data), 32'h11);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("drain_valid%0d", i), 32'(tx_valid), 32'h1);
      check($sformatf("drain_byte%0d", i), 32'(tx_data), 32'h11 * (i + 1));
      step();
    end
    check("drain_empty", 32'(tx_valid), 32'h0);
    wr(A_STATUS, 32'h4);
    rd(A_STATUS, r); check("ovf_clear", r, 32'h1);

    // 5. Push into an empty FIFO, then push and pop in the same cycle.
    tx_ready = 1'b0;
    wr(A_TX, 32'h77);
    check("no_fallthrough_valid", 32'(tx_valid), 32'h1);
    tx_ready = 1'b1;
    wr(A_TX, 32'h66);
    rd(A_STATUS, r); check("pushpop_count", r, 32'h100);
    check("pushpop_next", 32'(tx_data), 32'h66);
    step();
    check("pushpop_done", 32'(tx_valid), 32'h0);

    // 6. Counter delta, then a reset pulse in the middle of a transfer.
    rd(A_CYCLES, a);
    repeat (10) step();
    rd(A_CYCLES, b);
    check("cycles_delta", b - a, 32'd10);
    tx_ready = 1'b0;
    wr(A_TX, 32'h01); wr(A_TX, 32'h02); wr(A_TX, 32'h03);
    rd(A_STATUS, r); check("three_queued", r, 32'h300);
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(tx_valid), 32'h0);
    rd(A_STATUS, r); check("midrst_status", r, 32'h1);
    rd(A_CYCLES, r); check("midrst_cycles", r, 32'h0);
    step();
    reset = 1'b1;
    rd(A_CYCLES, r); check("cycles_held_in_reset", r, 32'h0);
    step();
    rd(A_CYCLES, r); check("cycles_resume", r, 32'h1);

    // Randomized phase against the reference model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      int op;
      op  = $urandom_range(0, 9);
      we  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) == 0);
      wd  = $urandom;
      case (op)
        0, 1, 2: begin
          addr = $urandom;
          if (addr[31:8] == 24'hFFFFFF) addr[31] = 1'b0;
        end
        3: addr = A_GPIO;
        4, 5: addr = A_TX;
        6: begin addr = A_STATUS; if ($urandom_range(0, 1) == 1) wd[2] = 1'b1; end
        7: addr = A_CYCLES;
        default: addr = {24'hFFFFFF, 8'($urandom_range(0, 255))};
      endcase
      memwrite = we; aluout = addr; writedata = wd; tx_ready = rdy;
      #1;
      if (addr[31:8] == 24'hFFFFFF || m_known[(addr / 4) % RAM_WORDS])
        check("rand_readdata", readdata, model_read(addr));
      check("rand_gpio", gpio_out, m_gpio);
      check("rand_tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("rand_tx_data", 32'(tx_data), 32'(m_q[0]));
      model_edge(we, addr, wd, rdy);
      step();
    end
    memwrite = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder for the single-cycle core's data port: `memwrite`, `aluout` as address, `writedata` in; `readdata` out.
- Holds word-addressed data RAM plus a memory-mapped I/O page: GPIO output register, free-running cycle counter, and a byte TX FIFO with valid/ready handshake to an external sink.
- Reads are combinational, because the core completes a load in one cycle.
- Writes and all state updates occur on the rising clock edge.

Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4, TX FIFO depth in bytes; power of two, 2..8.
- MMIO_PAGE, 24'hFFFFFF, value of address[31:8] that selects the MMIO page.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  write strobe from the core, sampled at the clock edge.
- aluout  input  32  byte address from the core.
- writedata  input  32  store data from the core.
- readdata  output  32  load data, combinational from address and current state.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  sink accepts the byte at the clock edge when tx_valid is high.
- gpio_out  output  32  GPIO register contents.

Behaviour:
- **Decode**
  - aluout[31:8]==MMIO_PAGE selects MMIO; otherwise RAM.
  - RAM index = aluout[log2(RAM_WORDS)+1:2]. Upper bits are ignored, so the RAM aliases/wraps. aluout[1:0] is ignored.
- **RAM**
  - Write on the edge when memwrite is high and RAM is selected.
  - readdata returns the stored word; a write is visible to reads from the next cycle.
  - RAM is not reset.
- **MMIO offsets (aluout[7:0])**
  - 0x00 GPIO: R/W. A write loads writedata; gpio_out updates the cycle after the edge.
  - 0x04 TXDATA:
    - A write pushes writedata[7:0] if the FIFO is not full.
    - If full (judged before the edge), the push is dropped and sticky `ovf` is set. A full FIFO rejects a push even if a pop happens in the same cycle.
    - Reads return 0.
  - 0x08 STATUS: read = {20'b0, count[3:0], 5'b0, ovf, full, empty}. A write with writedata[2]=1 clears `ovf`; other bits are ignored.
  - 0x0C CYCLES: 32-bit counter that increments every cycle and wraps FFFFFFFF->0. Writes are ignored.
  - Any other offset: read 0, write ignored.
- **TX FIFO**
  - Circular buffer with rd/wr pointers and a count (0..FIFO_DEPTH).
  - tx_valid = (count!=0); tx_data = mem[rd].
  - Pop on the edge when tx_valid && tx_ready.
  - Push and pop in the same cycle (non-empty, non-full): count is unchanged and both pointers advance.
  - No fall-through: a byte pushed into an empty FIFO raises tx_valid on the next cycle.
  - tx_data stays stable while tx_valid && !tx_ready. Pointers wrap modulo FIFO_DEPTH.
- **Reset (async, reset==0)**
  - gpio_out=0, cycle counter=0, FIFO empty (count=0, pointers=0), tx_valid=0, ovf=0.
  - readdata follows the decode with these values.
  - Asserting reset mid-transfer discards FIFO contents immediately.
  - Counting resumes on the first edge after deassertion.
- memwrite with no defined target has no side effects.

Test Plan:
1. **Reset values:** assert reset with tx_ready=1 -> tx_valid=0, gpio_out=0, STATUS read=32'h1, CYCLES read=0.
2. **RAM write/read and aliasing:** write 32'hDEADBEEF to 0x10, read 0x10 -> DEADBEEF. Read 0x10+4*RAM_WORDS (0x110) -> DEADBEEF (alias). Read 0x13 -> DEADBEEF.
3. **GPIO:** write 32'h0000A5A5 to FFFFFF00 -> gpio_out=A5A5 after the edge; read back A5A5. Write to FFFFFF40 -> gpio_out unchanged, read 0.
4. **TX FIFO fill and drain:**
   - With tx_ready=0, push 0x11,0x22,0x33,0x44 -> STATUS=32'h402 (count 4, full).
   - Push 0x55 -> dropped, STATUS=32'h406.
   - Set tx_ready=1 -> bytes 11,22,33,44 on consecutive cycles, then tx_valid=0.
   - Write STATUS with 0x4 -> STATUS=32'h1.
5. **Simultaneous push/pop:** with 1 byte queued and tx_ready=1, push 0x66 -> count stays 1; next byte out is 0x66, in order.
6. **Counter and mid-operation reset:**
   - Read CYCLES twice, 10 cycles apart -> difference 10.
   - Queue 3 bytes, pulse reset -> tx_valid drops immediately, STATUS=32'h1, CYCLES restarts from 0.
